// File: rtl/xge_wb_cmd_engine.sv
// Queued Wishbone master for the 10GE MAC register block: pops register commands,
// runs one single cycle each with programmable gaps and timeout, returns a status.
module xge_wb_cmd_engine #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int PRE_GAP       = 10,
    parameter int POST_GAP      = 10,
    parameter int TIMEOUT       = 16,
    parameter int ADDR_CHECK_EN = 1
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_val,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_code,
    output logic              busy,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_MAX = (PRE_GAP > POST_GAP) ? ((PRE_GAP > TIMEOUT) ? PRE_GAP : TIMEOUT)
                                                  : ((POST_GAP > TIMEOUT) ? POST_GAP : TIMEOUT);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ACCESS, ST_POST} state_t;

    // Only the MAC's implemented registers are reachable when checking is enabled.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(32'h00)) || (a == ADDR_W'(32'h08)) ||
               (a == ADDR_W'(32'h0C)) || (a == ADDR_W'(32'h10));
    endfunction

    logic              mem_we_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s, pop_s;

    state_t            state_q;
    logic [GAP_W-1:0]  gap_q;
    logic              hold_we_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              rsp_val_q, wb_cyc_q, wb_stb_q, wb_we_q;
    logic [DATA_W-1:0] rsp_rdata_q, wb_dat_q;
    logic [1:0]        rsp_code_q;
    logic [ADDR_W-1:0] wb_adr_q;

    assign cmd_rdy = (count_q != CNT_W'(FIFO_DEPTH));
    assign push_s  = cmd_val && cmd_rdy;
    assign pop_s   = (state_q == ST_IDLE) && (count_q != CNT_W'(0));
    assign busy    = (state_q != ST_IDLE) || (count_q != CNT_W'(0));

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are only read when the occupancy says they are valid
    always_ff @(posedge clk_156m25) begin
        if (push_s) begin
            mem_we_q[wr_ptr_q]   <= cmd_we;
            mem_addr_q[wr_ptr_q] <= cmd_addr;
            mem_data_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Command sequencer with registered bus and response outputs
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= GAP_W'(0);
            hold_we_q   <= 1'b0;
            hold_addr_q <= ADDR_W'(0);
            hold_data_q <= DATA_W'(0);
            rsp_val_q   <= 1'b0;
            rsp_rdata_q <= DATA_W'(0);
            rsp_code_q  <= 2'b00;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= ADDR_W'(0);
            wb_dat_q    <= DATA_W'(0);
        end else begin
            rsp_val_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        hold_we_q   <= mem_we_q[rd_ptr_q];
                        hold_addr_q <= mem_addr_q[rd_ptr_q];
                        hold_data_q <= mem_data_q[rd_ptr_q];
                        gap_q       <= GAP_W'(0);
                        if ((ADDR_CHECK_EN != 0) && !addr_legal(mem_addr_q[rd_ptr_q])) begin
                            rsp_val_q   <= 1'b1;
                            rsp_code_q  <= 2'b10;
                            rsp_rdata_q <= DATA_W'(0);
                            state_q     <= (POST_GAP == 0) ? ST_IDLE : ST_POST;
                        end else begin
                            state_q <= (PRE_GAP == 0) ? ST_ACCESS : ST_PRE;
                        end
                    end
                end
                ST_PRE: begin
                    if (gap_q == GAP_W'(PRE_GAP - 1)) begin
                        gap_q   <= GAP_W'(0);
                        state_q <= ST_ACCESS;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                ST_ACCESS: begin
                    // First ACCESS cycle launches the bus; ack is only honoured once cyc is up.
                    if (!wb_cyc_q) begin
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        wb_we_q  <= hold_we_q;
                        wb_adr_q <= hold_addr_q;
                        wb_dat_q <= hold_data_q;
                        gap_q    <= GAP_W'(0);
                    end else if (wb_ack_i || (gap_q == GAP_W'(TIMEOUT - 1))) begin
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        wb_we_q     <= 1'b0;
                        wb_adr_q    <= ADDR_W'(0);
                        wb_dat_q    <= DATA_W'(0);
                        rsp_val_q   <= 1'b1;
                        rsp_code_q  <= wb_ack_i ? 2'b00 : 2'b01;
                        rsp_rdata_q <= (wb_ack_i && !hold_we_q) ? wb_dat_i : DATA_W'(0);
                        gap_q       <= GAP_W'(0);
                        state_q     <= (POST_GAP == 0) ? ST_IDLE : ST_POST;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                ST_POST: begin
                    if (gap_q == GAP_W'(POST_GAP - 1)) begin
                        gap_q   <= GAP_W'(0);
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_val   = rsp_val_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_code  = rsp_code_q;
    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_stb_q;
    assign wb_we_o   = wb_we_q;
    assign wb_adr_o  = wb_adr_q;
    assign wb_dat_o  = wb_dat_q;

endmodule

// File: tb/tb_xge_wb_cmd_engine.sv
// Directed bench for xge_wb_cmd_engine: default instance plus one with address checking off.
module tb_xge_wb_cmd_engine;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25_n;
    logic        cmd_val, cmd_we, cmd_rdy;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_val, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i;

    logic        cmd_val2, cmd_rdy2, rsp_val2, busy2;
    logic [31:0] rsp_rdata2, wb_dat_o2;
    logic [1:0]  rsp_code2;
    logic        wb_cyc2, wb_stb2, wb_we2, wb_ack2;
    logic [7:0]  wb_adr2;

    always #5 clk_156m25 = ~clk_156m25;
    assign wb_ack2 = wb_cyc2;

    xge_wb_cmd_engine dut (
        .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_val(rsp_val), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
        .busy(busy), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    xge_wb_cmd_engine #(.ADDR_CHECK_EN(0)) dut_nc (
        .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n),
        .cmd_val(cmd_val2), .cmd_rdy(cmd_rdy2), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_val(rsp_val2), .rsp_rdata(rsp_rdata2), .rsp_code(rsp_code2),
        .busy(busy2), .wb_cyc_o(wb_cyc2), .wb_stb_o(wb_stb2), .wb_we_o(wb_we2),
        .wb_adr_o(wb_adr2), .wb_dat_o(wb_dat_o2), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Bus/response recorders (filled by the negedge monitor)
    int rise_q[$], fall_q[$], addr_q[$], we_q[$], bdat_q[$];
    int rsp_e_q[$], code_q[$], rdata_q[$];
    int we_cyc_n = 0, idle_bad = 0;
    int n_bus2 = 0, n_rsp2 = 0, adr2_last = -1, we2_last = -1, code2_last = -1;
    logic prev_cyc = 1'b0, prev_cyc2 = 1'b0;
    int scnt = 0;
    int ack_delay = 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int qg(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(posedge clk_156m25) edge_n <= edge_n + 1;

    // Monitor plus slave model with programmable ack delay (-1 = never)
    always @(negedge clk_156m25) begin
        if (wb_cyc_o && !prev_cyc) begin
            rise_q.push_back(edge_n);
            addr_q.push_back(int'(wb_adr_o));
            we_q.push_back(int'(wb_we_o));
            bdat_q.push_back(int'(wb_dat_o));
        end
        if (!wb_cyc_o && prev_cyc) fall_q.push_back(edge_n);
        if (wb_cyc_o && wb_we_o) we_cyc_n++;
        if (!wb_cyc_o && (wb_we_o || wb_stb_o || wb_adr_o != 8'h00 || wb_dat_o != 32'h0)) idle_bad++;
        prev_cyc = wb_cyc_o;
        if (rsp_val) begin
            rsp_e_q.push_back(edge_n);
            code_q.push_back(int'(rsp_code));
            rdata_q.push_back(int'(rsp_rdata));
        end
        if (!wb_cyc_o) begin
            wb_ack_i = 1'b0;
            scnt = 0;
        end else begin
            if (ack_delay >= 0 && scnt == ack_delay) wb_ack_i = 1'b1;
            scnt++;
        end
        if (wb_cyc2 && !prev_cyc2) begin
            n_bus2++;
            adr2_last = int'(wb_adr2);
            we2_last  = int'(wb_we2);
        end
        prev_cyc2 = wb_cyc2;
        if (rsp_val2) begin
            n_rsp2++;
            code2_last = int'(rsp_code2);
        end
    end

    task automatic step();
        @(posedge clk_156m25);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int e, output int w);
        w = 0;
        while (!cmd_rdy && w < 200) begin
            step();
            w++;
        end
        if (!cmd_rdy) chk("push_wait", int'(cmd_rdy), 1);
        cmd_val = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        step();
        e = edge_n;
        cmd_val = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int k = 0;
        while (rsp_e_q.size() < n && k < 400) begin
            step();
            k++;
        end
        chk(tag, rsp_e_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        chk(tag, int'(busy), 0);
    endtask

    int e, w, nb, nr, we0, li;
    int t4_addr[5] = '{8'h00, 8'h08, 8'h0C, 8'h10, 8'h00};
    int t4_we[5]   = '{1, 1, 0, 1, 0};

    initial begin
        reset_156m25_n = 1'b0;
        cmd_val = 1'b0; cmd_val2 = 1'b0; cmd_we = 1'b0;
        cmd_addr = 8'h00; cmd_wdata = 32'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0;
        steps(3);
        chk("rst_cyc", int'(wb_cyc_o), 0);
        chk("rst_rsp_val", int'(rsp_val), 0);
        chk("rst_rsp_code", int'(rsp_code), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_rdy", int'(cmd_rdy), 1);
        chk("rst_adr", int'(wb_adr_o), 0);
        reset_156m25_n = 1'b1;
        steps(2);

        // 1: write 0x00, ack one cycle after stb
        push(1'b1, 8'h00, 32'h1, e, w);
        wait_rsp("t1_rsp", 1);
        chk("t1_latency", qg(rise_q, 0) - e, 12);
        chk("t1_cyc_len", qg(fall_q, 0) - qg(rise_q, 0), 2);
        chk("t1_we", qg(we_q, 0), 1);
        chk("t1_adr", qg(addr_q, 0), 8'h00);
        chk("t1_dat", qg(bdat_q, 0), 32'h1);
        chk("t1_rsp_edge", qg(rsp_e_q, 0) - qg(fall_q, 0), 0);
        chk("t1_code", qg(code_q, 0), 0);
        chk("t1_rdata", qg(rdata_q, 0), 0);
        wait_idle("t1_idle");
        chk("t1_busy_drop", edge_n - qg(fall_q, 0), 10);

        // 2: read 0x0C returns DEADBEEF
        wb_dat_i = 32'hDEADBEEF;
        we0 = we_cyc_n;
        push(1'b0, 8'h0C, 32'h0, e, w);
        wait_rsp("t2_rsp", 2);
        chk("t2_rdata", qg(rdata_q, 1), 32'hDEADBEEF);
        chk("t2_code", qg(code_q, 1), 0);
        chk("t2_we_low", we_cyc_n - we0, 0);
        chk("t2_adr", qg(addr_q, 1), 8'h0C);
        wait_idle("t2_idle");

        // 3: read 0x10 never acked, then a queued write still runs
        ack_delay = -1;
        push(1'b0, 8'h10, 32'h0, e, w);
        push(1'b1, 8'h08, 32'h5, e, w);
        wait_rsp("t3_rsp_a", 3);
        ack_delay = 1;
        chk("t3_cyc_len", qg(fall_q, 2) - qg(rise_q, 2), 16);
        chk("t3_code", qg(code_q, 2), 1);
        chk("t3_rdata", qg(rdata_q, 2), 0);
        wait_rsp("t3_rsp_b", 4);
        chk("t3_next_adr", qg(addr_q, 3), 8'h08);
        chk("t3_next_dat", qg(bdat_q, 3), 32'h5);
        chk("t3_next_code", qg(code_q, 3), 0);

        // 4: fill FIFO while engine is in its post gap, fifth held
        wb_dat_i = 32'h12345678;
        for (int i = 0; i < 4; i++) push(t4_we[i][0], t4_addr[i][7:0], 32'hA0 + i, e, w);
        chk("t4_full", int'(cmd_rdy), 0);
        push(t4_we[4][0], t4_addr[4][7:0], 32'hA4, e, w);
        chk("t4_held", int'(w > 0), 1);
        wait_rsp("t4_rsp", 9);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_adr%0d", i), qg(addr_q, 4 + i), t4_addr[i]);
            chk($sformatf("t4_we%0d", i), qg(we_q, 4 + i), t4_we[i]);
            chk($sformatf("t4_code%0d", i), qg(code_q, 4 + i), 0);
            chk($sformatf("t4_rdata%0d", i), qg(rdata_q, 4 + i), t4_we[i] != 0 ? 0 : 32'h12345678);
            chk($sformatf("t4_gap%0d", i), qg(rise_q, 4 + i) - qg(fall_q, 3 + i), 22);
        end
        wait_idle("t4_idle");

        // 5: illegal address rejected; accepted when checking is disabled
        nb = rise_q.size();
        push(1'b1, 8'h04, 32'h77, e, w);
        wait_rsp("t5_rsp", 10);
        chk("t5_code", qg(code_q, 9), 2);
        chk("t5_rdata", qg(rdata_q, 9), 0);
        chk("t5_rsp_lat", qg(rsp_e_q, 9) - e, 1);
        wait_idle("t5_idle");
        chk("t5_no_bus", rise_q.size(), nb);
        cmd_val2 = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'h77;
        step();
        cmd_val2 = 1'b0;
        for (int k = 0; k < 60 && n_rsp2 == 0; k++) step();
        chk("t5_nc_bus", n_bus2, 1);
        chk("t5_nc_adr", adr2_last, 8'h04);
        chk("t5_nc_we", we2_last, 1);
        chk("t5_nc_code", code2_last, 0);

        // 6: reset during ACCESS with two commands queued
        ack_delay = -1;
        push(1'b0, 8'h08, 32'h0, e, w);
        for (int k = 0; k < 30 && !wb_cyc_o; k++) step();
        chk("t6_cyc_up", int'(wb_cyc_o), 1);
        push(1'b1, 8'h00, 32'h11, e, w);
        push(1'b1, 8'h10, 32'h22, e, w);
        nr = rsp_e_q.size();
        reset_156m25_n = 1'b0;
        step();
        chk("t6_cyc", int'(wb_cyc_o), 0);
        chk("t6_stb", int'(wb_stb_o), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cmd_rdy", int'(cmd_rdy), 1);
        reset_156m25_n = 1'b1;
        ack_delay = 1;
        steps(40);
        chk("t6_no_rsp", rsp_e_q.size(), nr);
        chk("t6_still_idle", int'(busy), 0);
        push(1'b1, 8'h10, 32'hCAFE, e, w);
        wait_rsp("t6_rsp", nr + 1);
        li = rise_q.size() - 1;
        chk("t6_latency", qg(rise_q, li) - e, 12);
        chk("t6_adr", qg(addr_q, li), 8'h10);
        chk("t6_code", qg(code_q, nr), 0);
        wait_idle("t6_idle");

        chk("idle_bus_zero", idle_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xge_wb_cmd_engine.md
Name: xge_wb_cmd_engine

Overview:
- Synthesizable Wishbone master that replaces the fixed-timing write/read tasks used to configure the 10GE MAC register block.
- Accepts register commands through a parametrised-depth command FIFO and issues single Wishbone cycles with programmable pre/post gaps.
- Waits for ack and times out if none arrives; returns read data and status on a response port.
- Sits between test/config logic and the MAC's wb_* slave port, on the clk_156m25 domain.

Parameters:
ADDR_W, 8, Wishbone address width
DATA_W, 32, Wishbone data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
PRE_GAP, 10, idle cycles between FIFO pop and cyc assertion (0 allowed)
POST_GAP, 10, idle cycles after cycle end before next pop (0 allowed)
TIMEOUT, 16, max cycles cyc held without ack (>=1)
ADDR_CHECK_EN, 1, 1 = reject addresses other than 0x00/0x08/0x0C/0x10

Ports:
clk_156m25  in  1  clock
reset_156m25_n  in  1  synchronous active-low reset
cmd_val  in  1  command valid
cmd_rdy  out  1  FIFO not full
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  DATA_W  write data
rsp_val  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_code  out  2  00 ok, 01 timeout, 10 illegal address
busy  out  1  engine not idle or FIFO not empty
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone ack

Behaviour:
- Reset is synchronous and active-low on clk_156m25 / reset_156m25_n.
- Reset values:
  - all wb_* outputs 0, rsp_val 0, rsp_rdata 0, rsp_code 00, busy 0, cmd_rdy 1.
  - FIFO flushed, state IDLE, counters 0.
- Reset mid-cycle drops wb_cyc_o/wb_stb_o on the next edge. No response is issued for the aborted or queued commands.
- FIFO:
  - Push when cmd_val && cmd_rdy.
  - cmd_rdy = !full, registered-count based.
  - Simultaneous push and pop when full is not allowed: cmd_rdy is already 0. Push and pop in the same cycle when not full keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, PRE, ACCESS, POST.
  - IDLE: when FIFO not empty, pop head into a holding register.
    - If ADDR_CHECK_EN and the address is illegal: pulse rsp_val the next cycle with code 10, go to POST, no bus activity.
    - Otherwise go to PRE, or to ACCESS if PRE_GAP=0.
  - PRE: count PRE_GAP cycles, then ACCESS.
  - ACCESS: cyc=stb=1, we/adr/dat from the holding register, held stable until the cycle ends.
    - wb_ack_i sampled high at edge M: cyc/stb/we drop after edge M. rsp_val=1 in the cycle after M with code 00. rsp_rdata = wb_dat_i captured at M for reads, 0 for writes.
    - No ack after TIMEOUT ACCESS cycles: drop cyc/stb, rsp_val with code 01, rsp_rdata 0.
    - Ack arriving on the same edge as timeout expiry counts as success.
    - Exit to POST.
  - POST: count POST_GAP cycles, then IDLE.
- wb_adr_o/wb_dat_o/wb_we_o are driven 0 whenever wb_cyc_o=0. Values are deterministic, never random.
- Latency, idle engine with empty FIFO, command pushed at edge N:
  - pop at N+1;
  - wb_cyc_o high from edge N+2+PRE_GAP;
  - best-case back-to-back throughput is one command per (PRE_GAP + ack latency + 1 + POST_GAP + 1) cycles.
- busy = (state != IDLE) || FIFO not empty. busy deasserts the cycle POST completes with an empty FIFO.
- wb_ack_i outside ACCESS is ignored.
- Exactly one rsp_val per popped command.

Test Plan:
1. Write 0x00 data 0x00000001, slave acks 1 cycle after stb: wb_cyc_o high at push+12 for exactly 2 cycles (defaults); rsp_val with code 00, rsp_rdata 0.
2. Read 0x0C, slave returns 0xDEADBEEF with ack: rsp_rdata = 0xDEADBEEF, code 00, wb_we_o = 0 throughout.
3. Read 0x10, slave never acks: cyc held exactly 16 cycles, then dropped; rsp code 01, rsp_rdata 0. A following queued command still executes.
4. Push 4 commands back-to-back plus a 5th: cmd_rdy low after the 4th push, 5th held. All 5 complete in order with 5 rsp_val pulses and at least 10 idle cycles between bus cycles.
5. Write to 0x04 with ADDR_CHECK_EN=1: no cyc, rsp code 10. Repeat with ADDR_CHECK_EN=0: bus write to 0x04 issued.
6. Assert reset_156m25_n low during ACCESS with 2 commands queued: cyc 0 after the next edge, no rsp_val, busy 0, cmd_rdy 1; a fresh command afterward executes normally.
